// File: rtl/rand_range_sampler.sv
// rand_range_sampler
//  Turns the free-running 32-bit LFSR value into a uniformly distributed
//  integer in [0, range-1] using mask-and-reject sampling. After MAX_TRIES
//  rejected samples it falls back to (cand - range), which is always in range
//  because mask < 2*range. The LFSR is advanced only while sampling.
//
//  Optional feature macro: STUCK_DETECT_EN
//   When defined, a run of STUCK_CYCLES identical consecutive samples sets the
//   sticky 'stuck' flag. While it is set, every request resolves on its first
//   SAMPLE edge. When undefined, 'stuck' is tied to 0.
//
//  Ports
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   lfsr_value   current LFSR output (only [OUT_W-1:0] feeds the sample)
//   lfsr_enable  advance request to the LFSR, high only in SAMPLE
//   req          request a new number, sampled only in IDLE
//   range        exclusive upper bound, 0 means 2^OUT_W, latched at acceptance
//   busy         high while in SAMPLE
//   valid        one-cycle pulse, rand_out updated
//   rand_out     result, held until the next valid
//   fallback     qualifies valid: result came from the fallback path
//   stuck        sticky LFSR-stuck flag
//
//  state  | meaning
//  IDLE   | waiting for req; latches range and builds the mask
//  SAMPLE | one masked sample per edge until accepted or tries run out

module rand_range_sampler #(
   parameter int OUT_W        = 8,
   parameter int MAX_TRIES    = 15,
   parameter int STUCK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [31:0]      lfsr_value,
   output logic             lfsr_enable,
   input  logic             req,
   input  logic [OUT_W-1:0] range,
   output logic             busy,
   output logic             valid,
   output logic [OUT_W-1:0] rand_out,
   output logic             fallback,
   output logic             stuck
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] SAMPLE = 1'b1;

   localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

   logic [0:0]   state;
   logic [7:0]   tries;
   logic [OUT_W:0] range_q;
   logic [OUT_W:0] mask_q;

   logic [OUT_W:0] range_full;
   logic [OUT_W:0] range_m1;
   logic [OUT_W:0] mask_new;
   logic [OUT_W:0] cand;
   logic [OUT_W:0] fb_val;
   logic           stuck_hit;

   // Upper LFSR bits only matter to the optional stuck compare.
   logic unused_lfsr_bits;
   assign unused_lfsr_bits = ^lfsr_value[31:OUT_W];

   assign lfsr_enable = (state == SAMPLE);
   assign busy        = (state == SAMPLE);

   // range 0 stands for the full 2^OUT_W span, hence the extra bit.
   assign range_full = (range == '0) ? ((OUT_W+1)'(1) << OUT_W) : {1'b0, range};
   assign range_m1   = range_full - 1'b1;

   // Smear the top set bit of range-1 downward: smallest 2^k-1 >= range-1.
   always_comb begin
      mask_new = range_m1;
      for (int i = 1; i <= OUT_W; i++) begin
         mask_new = mask_new | (range_m1 >> i);
      end
   end

   assign cand   = {1'b0, lfsr_value[OUT_W-1:0]} & mask_q;
   assign fb_val = cand - range_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= IDLE;
         tries    <= '0;
         range_q  <= '0;
         mask_q   <= '0;
         valid    <= 1'b0;
         fallback <= 1'b0;
         rand_out <= '0;
      end else begin
         valid    <= 1'b0;
         fallback <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  range_q <= range_full;
                  mask_q  <= mask_new;
                  tries   <= '0;
                  state   <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (cand < range_q) begin
                  rand_out <= cand[OUT_W-1:0];
                  valid    <= 1'b1;
                  state    <= IDLE;
               end else if ((tries == TRY_LAST) || stuck_hit) begin
                  rand_out <= fb_val[OUT_W-1:0];
                  valid    <= 1'b1;
                  fallback <= 1'b1;
                  state    <= IDLE;
               end else begin
                  tries <= tries + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STUCK_DETECT_EN
   logic [31:0] prev_q;
   logic [7:0]  same_cnt;
   logic        stuck_q;
   logic        same;

   // The first SAMPLE edge of a request has no earlier sample to compare
   // against; tries != 0 marks every later edge of the same request.
   assign same = (state == SAMPLE) && (tries != '0) && (lfsr_value == prev_q);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         prev_q   <= '0;
         same_cnt <= '0;
         stuck_q  <= 1'b0;
      end else begin
         prev_q <= lfsr_value;
         if (same) begin
            if (same_cnt != 8'hFF) begin
               same_cnt <= same_cnt + 1'b1;
            end
            if (same_cnt == 8'(STUCK_CYCLES - 2)) begin
               stuck_q <= 1'b1;
            end
         end else begin
            same_cnt <= '0;
         end
      end
   end

   assign stuck_hit = stuck_q;
   assign stuck     = stuck_q;
`else
   assign stuck_hit = 1'b0;
   assign stuck     = 1'b0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
module tb_rand_range_sampler;

   localparam int OUT_W = 8;

   logic             clk;
   logic             clr_n;
   logic [31:0]      lfsr_value;
   logic             lfsr_enable;
   logic             req;
   logic [OUT_W-1:0] range;
   logic             busy;
   logic             valid;
   logic [OUT_W-1:0] rand_out;
   logic             fallback;
   logic             stuck;

   int total;
   int passed;

   rand_range_sampler #(.OUT_W(OUT_W), .MAX_TRIES(15), .STUCK_CYCLES(4)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .lfsr_value  (lfsr_value),
      .lfsr_enable (lfsr_enable),
      .req         (req),
      .range       (range),
      .busy        (busy),
      .valid       (valid),
      .rand_out    (rand_out),
      .fallback    (fallback),
      .stuck       (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; req = 1'b0; range = '0; lfsr_value = '0;
      tick(); tick();
      total++; if ({busy, valid, fallback, stuck, lfsr_enable} !== 5'b0)
         $display("FAIL reset_flags: got %b expected 00000", {busy, valid, fallback, stuck, lfsr_enable}); else passed++;
      total++; if (rand_out !== 8'h00)
         $display("FAIL reset_rand_out: got %h expected 00", rand_out); else passed++;
      clr_n = 1'b1;
      lfsr_value = 32'h0000000C; range = 8'd10; req = 1'b1;
      tick();
      req = 1'b0;
      total++; if (busy !== 1'b1)
         $display("FAIL reset_pre_busy: got %b expected 1", busy); else passed++;
      tick(); tick();
      #2 clr_n = 1'b0;
      #1;
      total++; if ({busy, valid, lfsr_enable} !== 3'b000)
         $display("FAIL reset_mid_sample: got %b expected 000", {busy, valid, lfsr_enable}); else passed++;
      tick();
      clr_n = 1'b1;
      lfsr_value = 32'h00000007; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd7)
         $display("FAIL reset_recover: got valid=%b rand=%0d expected valid=1 rand=7", valid, rand_out); else passed++;
      tick();
   endtask

   task automatic test_basic();
      lfsr_value = 32'hFFFFFF17; range = 8'd10; req = 1'b1;
      tick();
      req = 1'b0;
      total++; if ({busy, lfsr_enable, valid} !== 3'b110)
         $display("FAIL basic_accept: got %b expected 110", {busy, lfsr_enable, valid}); else passed++;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd7 || fallback !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_result: got v=%b r=%0d f=%b b=%b expected v=1 r=7 f=0 b=0", valid, rand_out, fallback, busy); else passed++;
      tick();
      total++; if (valid !== 1'b0 || rand_out !== 8'd7)
         $display("FAIL basic_hold: got v=%b r=%0d expected v=0 r=7", valid, rand_out); else passed++;
   endtask

   task automatic test_fallback();
      int n;
      int exp_n;
      bit seen;
`ifdef STUCK_DETECT_EN
      exp_n = 5;
`else
      exp_n = 15;
`endif
      lfsr_value = 32'h0000000C; range = 8'd10; req = 1'b1;
      tick();
      req = 1'b0;
      n = 0; seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         tick();
         n = i;
         if (valid) seen = 1'b1;
      end
      total++; if (!seen || n != exp_n)
         $display("FAIL fallback_latency: got %0d edges (seen=%b) expected %0d", n, seen, exp_n); else passed++;
      total++; if (rand_out !== 8'd2 || fallback !== 1'b1)
         $display("FAIL fallback_result: got r=%0d f=%b expected r=2 f=1", rand_out, fallback); else passed++;
      tick();
      total++; if (valid !== 1'b0 || fallback !== 1'b0)
         $display("FAIL fallback_clear: got v=%b f=%b expected 0 0", valid, fallback); else passed++;
`ifndef STUCK_DETECT_EN
      total++; if (stuck !== 1'b0)
         $display("FAIL stuck_tied_low: got %b expected 0", stuck); else passed++;
`endif
   endtask

   task automatic test_full_range();
      lfsr_value = 32'h000000FF; range = 8'd0; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'hFF || fallback !== 1'b0)
         $display("FAIL range0: got v=%b r=%h f=%b expected v=1 r=ff f=0", valid, rand_out, fallback); else passed++;
      range = 8'd1; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'h00 || fallback !== 1'b0)
         $display("FAIL range1: got v=%b r=%h f=%b expected v=1 r=00 f=0", valid, rand_out, fallback); else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      lfsr_value = 32'h00000005; range = 8'd10; req = 1'b1;
      tick();
      total++; if (busy !== 1'b1)
         $display("FAIL b2b_accept: got busy=%b expected 1", busy); else passed++;
      range = 8'd3;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd5 || busy !== 1'b0)
         $display("FAIL b2b_first: got v=%b r=%0d b=%b expected v=1 r=5 b=0", valid, rand_out, busy); else passed++;
      tick();
      total++; if (valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL b2b_reaccept: got v=%b b=%b expected v=0 b=1", valid, busy); else passed++;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd1)
         $display("FAIL b2b_second: got v=%b r=%0d expected v=1 r=1", valid, rand_out); else passed++;
      req = 1'b0;
      tick();
      total++; if (valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL b2b_idle: got v=%b b=%b expected 0 0", valid, busy); else passed++;
   endtask

`ifdef STUCK_DETECT_EN
   task automatic test_stuck();
      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      lfsr_value = 32'h0000000C; range = 8'd10; req = 1'b1;
      tick();
      req = 1'b0;
      tick(); tick(); tick();
      total++; if (stuck !== 1'b0)
         $display("FAIL stuck_early: got %b expected 0", stuck); else passed++;
      tick();
      total++; if (stuck !== 1'b1 || busy !== 1'b1)
         $display("FAIL stuck_set: got s=%b b=%b expected 1 1", stuck, busy); else passed++;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd2 || fallback !== 1'b1)
         $display("FAIL stuck_resolve: got v=%b r=%0d f=%b expected 1 2 1", valid, rand_out, fallback); else passed++;
      req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      total++; if (valid !== 1'b1 || rand_out !== 8'd2 || fallback !== 1'b1 || stuck !== 1'b1)
         $display("FAIL stuck_first_edge: got v=%b r=%0d f=%b s=%b expected 1 2 1 1", valid, rand_out, fallback, stuck); else passed++;
      clr_n = 1'b0;
      #1;
      total++; if (stuck !== 1'b0)
         $display("FAIL stuck_reset: got %b expected 0", stuck); else passed++;
      tick();
      clr_n = 1'b1;
   endtask
`endif

   initial begin
      total = 0;
      passed = 0;
      test_reset();
      test_basic();
      test_fallback();
      test_full_range();
      test_back_to_back();
`ifdef STUCK_DETECT_EN
      test_stuck();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
